// File: rtl/microcode_store.sv
// microcode_store: writable microcode store, loaded byte-serially at boot and
// then read as a registered ROM indexed by {opcode, micro-op count}.
module microcode_store #(
   parameter int ADDR_W = 11,
   parameter int WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] ADDR,
   output logic [WORD_W-1:0] OUT,
   input  logic [7:0]        BOOTSTRAP_DATA,
   input  logic              BOOTSTRAP_VALID,
   output logic              BOOTSTRAP_READY,
   input  logic              BOOT_START,
   output logic [ADDR_W-1:0] BOOTSTRAP_ADDR,
   output logic              N_BOOTED,
   output logic [7:0]        CHECKSUM
);

   localparam int BYTES = WORD_W / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic {LOAD, RUN} state_t;

   state_t state, state_next;

   logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] pack;
   logic [WORD_W-1:0] write_word;
   logic              xfer;
   logic              last_byte;
   logic              last_word;
   logic              write_en;

   // Handshake and word-assembly decode; the top lane comes straight from the
   // incoming byte so a word is written on the same edge as its last byte.
   always_comb begin
      BOOTSTRAP_READY = (state == LOAD) && !BOOT_START;
      N_BOOTED        = (state == LOAD);
      xfer            = BOOTSTRAP_READY && BOOTSTRAP_VALID;
      last_byte       = (idx == IDX_W'(BYTES - 1));
      last_word       = &BOOTSTRAP_ADDR;
      write_en        = xfer && last_byte;
      write_word      = pack;
      write_word[WORD_W-1 -: 8] = BOOTSTRAP_DATA;
   end

   // Next-state logic: a restart always returns to LOAD, and the final byte
   // of the final word hands the store over to RUN.
   always_comb begin
      state_next = state;
      if (BOOT_START) begin
         state_next = LOAD;
      end else if (state == LOAD && write_en && last_word) begin
         state_next = RUN;
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Load bookkeeping: byte lane index, fill address, packing register and
   // running checksum; all cleared by reset or a restart pulse.
   always_ff @(posedge CLK) begin
      if (RST || BOOT_START) begin
         idx            <= '0;
         BOOTSTRAP_ADDR <= '0;
         CHECKSUM       <= '0;
         pack           <= '0;
      end else if (xfer) begin
         CHECKSUM <= CHECKSUM + BOOTSTRAP_DATA;
         for (int i = 0; i < BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
               pack[8*i +: 8] <= BOOTSTRAP_DATA;
            end
         end
         if (last_byte) begin
            idx            <= '0;
            BOOTSTRAP_ADDR <= BOOTSTRAP_ADDR + ADDR_W'(1);
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   // Storage write port; contents deliberately survive reset so only a
   // reload changes them.
   always_ff @(posedge CLK) begin
      if (write_en) begin
         mem[BOOTSTRAP_ADDR] <= write_word;
      end
   end

   // Registered read port; the no-op word is presented whenever not booted.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT <= '0;
      end else if (state == RUN && !BOOT_START) begin
         OUT <= mem[ADDR];
      end else begin
         OUT <= '0;
      end
   end

endmodule

// File: tb/tb_microcode_store.sv
// tb_microcode_store: directed bench for microcode_store, covering a 4x16
// instance and a 2x32 instance for width generality.
module tb_microcode_store;

   logic clock = 1'b0;

   logic        rst_a, valid_a, start_a;
   logic [3:0]  addr_a;
   logic [7:0]  data_a;
   logic [15:0] out_a;
   logic        ready_a, nb_a;
   logic [3:0]  baddr_a;
   logic [7:0]  cks_a;

   logic        rst_b, valid_b, start_b;
   logic [1:0]  addr_b;
   logic [7:0]  data_b;
   logic [31:0] out_b;
   logic        ready_b, nb_b;
   logic [1:0]  baddr_b;
   logic [7:0]  cks_b;

   int checks   = 0;
   int failures = 0;

   microcode_store #(.ADDR_W(4), .WORD_W(16)) dut_a (
      .CLK(clock), .RST(rst_a), .ADDR(addr_a), .OUT(out_a),
      .BOOTSTRAP_DATA(data_a), .BOOTSTRAP_VALID(valid_a),
      .BOOTSTRAP_READY(ready_a), .BOOT_START(start_a),
      .BOOTSTRAP_ADDR(baddr_a), .N_BOOTED(nb_a), .CHECKSUM(cks_a)
   );

   microcode_store #(.ADDR_W(2), .WORD_W(32)) dut_b (
      .CLK(clock), .RST(rst_b), .ADDR(addr_b), .OUT(out_b),
      .BOOTSTRAP_DATA(data_b), .BOOTSTRAP_VALID(valid_b),
      .BOOTSTRAP_READY(ready_b), .BOOT_START(start_b),
      .BOOTSTRAP_ADDR(baddr_b), .N_BOOTED(nb_b), .CHECKSUM(cks_b)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // Advance one edge and settle away from it.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Present one byte (or a bubble) to the selected instance for one cycle.
   task automatic applyStimulus(input bit sel, input logic [7:0] d, input logic v);
      if (sel == 1'b0) begin
         data_a  = d;
         valid_a = v;
      end else begin
         data_b  = d;
         valid_b = v;
      end
      tick();
   endtask

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Stream a 32-byte image into instance A: bytes 0x00..0x1F or all 0xFF.
   task automatic loadImageA(input bit fill_ff, input bit bubbles);
      for (int i = 0; i < 32; i++) begin
         if (bubbles) applyStimulus(1'b0, 8'h00, 1'b0);
         applyStimulus(1'b0, fill_ff ? 8'hFF : 8'(i), 1'b1);
         if (i == 30) checkOutput("nbooted_before_last", {31'b0, nb_a}, 32'h1);
      end
      valid_a = 1'b0;
   endtask

   // Issue a restart pulse to instance A with no byte offered.
   task automatic restartA;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; valid_a = 1'b0; start_a = 1'b0; addr_a = '0; data_a = '0;
      rst_b = 1'b1; valid_b = 1'b0; start_b = 1'b0; addr_b = '0; data_b = '0;
      tick();
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Reset state
      checkOutput("rst_out",   {16'b0, out_a}, 32'h0);
      checkOutput("rst_nboot", {31'b0, nb_a}, 32'h1);
      checkOutput("rst_ready", {31'b0, ready_a}, 32'h1);
      checkOutput("rst_cks",   {24'b0, cks_a}, 32'h0);
      checkOutput("rst_baddr", {28'b0, baddr_a}, 32'h0);

      // OUT stays zero while loading regardless of ADDR
      addr_a = 4'd3;
      tick();
      checkOutput("load_out_zero", {16'b0, out_a}, 32'h0);

      // Full load with continuous VALID
      loadImageA(1'b0, 1'b0);
      checkOutput("full_nboot", {31'b0, nb_a}, 32'h0);
      checkOutput("full_cks",   {24'b0, cks_a}, 32'hF0);
      checkOutput("full_baddr", {28'b0, baddr_a}, 32'h0);
      checkOutput("full_ready", {31'b0, ready_a}, 32'h0);
      addr_a = 4'd3;
      tick();
      checkOutput("full_word3", {16'b0, out_a}, 32'h0706);
      addr_a = 4'd15;
      tick();
      checkOutput("full_word15", {16'b0, out_a}, 32'h1F1E);

      // Bubbles: same image with VALID toggling
      restartA();
      checkOutput("restart_out",   {16'b0, out_a}, 32'h0);
      checkOutput("restart_nboot", {31'b0, nb_a}, 32'h1);
      loadImageA(1'b0, 1'b1);
      checkOutput("bub_cks",   {24'b0, cks_a}, 32'hF0);
      checkOutput("bub_nboot", {31'b0, nb_a}, 32'h0);

      // Read pipeline sweep, one address per cycle
      for (int k = 0; k < 16; k++) begin
         addr_a = 4'(k);
         tick();
         checkOutput($sformatf("sweep_%0d", k), {16'b0, out_a},
                     {16'b0, 8'(2*k+1), 8'(2*k)});
      end

      // VALID bytes after boot are ignored
      data_a = 8'h55;
      valid_a = 1'b1;
      #1;
      checkOutput("run_ready", {31'b0, ready_a}, 32'h0);
      tick();
      tick();
      valid_a = 1'b0;
      checkOutput("run_cks_frozen", {24'b0, cks_a}, 32'hF0);
      addr_a = 4'd5;
      tick();
      checkOutput("run_word5", {16'b0, out_a}, 32'h0B0A);

      // Restart mid-load with a byte offered in the restart cycle
      restartA();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h40 + 8'(i), 1'b1);
      checkOutput("mid_baddr", {28'b0, baddr_a}, 32'h2);
      checkOutput("mid_cks",   {24'b0, cks_a}, 32'h4A);
      start_a = 1'b1;
      data_a  = 8'hAA;
      valid_a = 1'b1;
      #1;
      checkOutput("start_ready", {31'b0, ready_a}, 32'h0);
      tick();
      start_a = 1'b0;
      valid_a = 1'b0;
      checkOutput("mid_restart_baddr", {28'b0, baddr_a}, 32'h0);
      checkOutput("mid_restart_cks",   {24'b0, cks_a}, 32'h0);
      loadImageA(1'b0, 1'b0);
      addr_a = 4'd2;
      tick();
      checkOutput("reload_word2", {16'b0, out_a}, 32'h0504);
      addr_a = 4'd0;
      tick();
      checkOutput("reload_word0", {16'b0, out_a}, 32'h0100);

      // Reset in RUN, then reload with 0xFFFF everywhere
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      checkOutput("runrst_out",   {16'b0, out_a}, 32'h0);
      checkOutput("runrst_nboot", {31'b0, nb_a}, 32'h1);
      checkOutput("runrst_ready", {31'b0, ready_a}, 32'h1);
      loadImageA(1'b1, 1'b0);
      checkOutput("ff_cks", {24'b0, cks_a}, 32'hE0);
      addr_a = 4'd7;
      tick();
      checkOutput("ff_word7", {16'b0, out_a}, 32'hFFFF);

      // Width generality: 4 words of 32 bits
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1);
         if (i == 15) checkOutput("b_nboot_before_last", {31'b0, nb_b}, 32'h1);
      end
      valid_b = 1'b0;
      checkOutput("b_nboot", {31'b0, nb_b}, 32'h0);
      checkOutput("b_cks",   {24'b0, cks_b}, 32'h88);
      addr_b = 2'd0;
      tick();
      checkOutput("b_word0", out_b, 32'h04030201);
      addr_b = 2'd3;
      tick();
      checkOutput("b_word3", out_b, 32'h100F0E0D);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/microcode_store.md
# microcode_store

Writable, parametrised microcode store that replaces the fixed microcode lookup. At power-up it is loaded byte-serially over the bootstrap channel, packing bytes into WORD_W-bit control words and writing every word of the store. It then serves as a registered microcode ROM indexed by {opcode, micro-op count} from control logic. A running byte checksum lets the bootstrap host verify the image. A load can be restarted without a full system reset.

## Interface
Parameters:
- ADDR_W, 11, word address width; depth = 2^ADDR_W words.
- WORD_W, 32, control word width; must be a multiple of 8 and at least 8; BYTES = WORD_W/8.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ADDR  in  ADDR_W  read address {opcode, microop_count} from control logic.
- OUT  out  WORD_W  registered control word; all-zero (no-op word) whenever not booted.
- BOOTSTRAP_DATA  in  8  image byte.
- BOOTSTRAP_VALID  in  1  BOOTSTRAP_DATA is valid this cycle.
- BOOTSTRAP_READY  out  1  store accepts a byte this cycle; a byte transfers when VALID && READY at an edge.
- BOOT_START  in  1  one-cycle pulse that restarts loading from word 0.
- BOOTSTRAP_ADDR  out  ADDR_W  word address currently being filled.
- N_BOOTED  out  1  high while loading; low once the full image is written.
- CHECKSUM  out  8  sum mod 256 of all bytes accepted since load start.

## Operation
- States: LOAD and RUN. Reset enters LOAD. Storage contents are not cleared by reset.
- Reset values: OUT=0, BOOTSTRAP_ADDR=0, byte index=0, CHECKSUM=0, N_BOOTED=1, BOOTSTRAP_READY=1.
- LOAD state:
  - BOOTSTRAP_READY=1 and N_BOOTED=1.
  - Each accepted byte goes into a packing register at byte lane idx, bits [8*idx+7:8*idx]. Lanes fill LSB first; byte 0 of each word is the least significant byte.
  - Each accepted byte updates CHECKSUM <= CHECKSUM + byte (mod 256) and increments idx.
  - Last byte of a word (idx == BYTES-1): in the same edge, write {byte, packed lower lanes} to mem[BOOTSTRAP_ADDR], set idx=0, and increment BOOTSTRAP_ADDR.
  - Last byte of word 2^ADDR_W-1: BOOTSTRAP_ADDR wraps to 0 and the state becomes RUN.
  - Bubbles (VALID=0) are allowed anywhere. Partial words are never written.
- RUN state:
  - BOOTSTRAP_READY=0 and N_BOOTED=0.
  - BOOTSTRAP_VALID is ignored; CHECKSUM and storage are frozen.
  - Each edge, OUT <= mem[ADDR].
- BOOT_START, in either state:
  - Next state is LOAD. Clears BOOTSTRAP_ADDR, idx and CHECKSUM, and sets OUT=0 and N_BOOTED=1.
  - Any byte presented in that same cycle is not accepted and not counted. BOOTSTRAP_READY is 0 in the BOOT_START cycle.
- Priority: RST > BOOT_START > byte transfer.
- RST or BOOT_START during LOAD discards the partial word. Words already written stay in memory until overwritten.

## Timing
- Bootstrap handshake: a transfer at edge t updates CHECKSUM, idx and BOOTSTRAP_ADDR, visible after edge t. One byte per cycle is sustained.
- Load time with continuous VALID: BYTES * 2^ADDR_W cycles from the first accepted byte.
- Boot complete: if the final byte transfers at edge t, N_BOOTED falls after edge t. ADDR presented in the following cycle appears on OUT after edge t+1.
- Read latency is 1 cycle: ADDR sampled at edge t gives OUT valid after edge t. OUT changes only at clock edges.
- Write-then-read of the same address cannot occur, since no reads happen in LOAD. OUT is forced to 0 in LOAD.
- Storage is a synchronous-read RAM of 2^ADDR_W x WORD_W, suitable for block RAM. The write port is used only in LOAD and the read port only in RUN.

## Test plan
All scenarios use ADDR_W=4, WORD_W=16 unless noted.
- Full load: stream bytes 0x00..0x1F with continuous VALID.
  - N_BOOTED falls after the 32nd byte and CHECKSUM=0xF0.
  - ADDR=3 gives OUT=0x0706 one cycle later; ADDR=15 gives 0x1F1E.
- Bubbles and backpressure: same image with VALID toggling every other cycle.
  - Memory and CHECKSUM are identical to the full-load case.
  - After boot, READY=0 and further VALID bytes leave CHECKSUM unchanged.
- Restart mid-load: send 5 bytes, then pulse BOOT_START with VALID=1 and byte 0xAA.
  - BOOTSTRAP_ADDR=0 and CHECKSUM=0; 0xAA is not counted.
  - A full reload then gives the correct words, including word 2.
- Reset in RUN: after a full load, assert RST for 1 cycle.
  - OUT=0, N_BOOTED=1, READY=1.
  - Reload every word as 0xFFFF; ADDR=7 then reads 0xFFFF.
- Read pipeline: after boot, sweep ADDR 0..15 on consecutive cycles.
  - OUT matches each word with exactly 1-cycle lag and no gaps.
- Width generality: ADDR_W=2, WORD_W=32, bytes 0x01..0x10.
  - Word 0 reads 0x04030201 and word 3 reads 0x100F0E0D.
  - CHECKSUM=0x88.
